// File: rtl/battleship_turn_ctrl.sv
// Two-player battleship turn sequencer: aim, shot scoring, result hold and win detection.
// Optional macro TURN_TIMEOUT_EN forfeits an aim turn (as a miss) after AIM_TIMEOUT idle cycles.
module battleship_turn_ctrl #(
    parameter int GRID_CELLS    = 36,
    parameter int SHIP_CELLS    = 10,
    parameter int RESULT_CYCLES = 50_000_000,
    parameter int AIM_TIMEOUT   = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_btn,
    input  logic                  fire,
    input  logic [5:0]            target,
    input  logic [GRID_CELLS-1:0] p1_board,
    input  logic [GRID_CELLS-1:0] p2_board,
    output logic                  start,
    output logic                  p1fire,
    output logic                  p2fire,
    output logic                  p1hit,
    output logic                  p1miss,
    output logic                  p2hit,
    output logic                  p2miss,
    output logic                  p1wins,
    output logic                  p2wins
);

    // state       | meaning
    // S_IDLE      | waiting for start_btn, start=1
    // S_P1_AIM    | player 1 choosing a target on player 2's board
    // S_P1_RESULT | player 1's shot result shown for RESULT_CYCLES
    // S_P2_AIM    | player 2 choosing a target on player 1's board
    // S_P2_RESULT | player 2's shot result shown for RESULT_CYCLES
    // S_P1_WIN    | game over, player 1 won (sticky until start_btn)
    // S_P2_WIN    | game over, player 2 won (sticky until start_btn)
    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_AIM,
        S_P1_RESULT,
        S_P2_AIM,
        S_P2_RESULT,
        S_P1_WIN,
        S_P2_WIN
    } state_t;

    localparam int CW = $clog2(SHIP_CELLS + 1);
    localparam int RW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [CW-1:0]         SHIP_MAX = CW'(SHIP_CELLS);
    localparam logic [RW-1:0]         RES_LOAD = RW'(RESULT_CYCLES - 1);
    localparam logic [GRID_CELLS-1:0] CELL_ONE = GRID_CELLS'(1);

    // target is 6 bits wide, so the board cannot exceed 64 cells
    if (GRID_CELLS < 1 || GRID_CELLS > 64 || SHIP_CELLS < 1 ||
        RESULT_CYCLES < 1 || AIM_TIMEOUT < 1) begin : g_bad_params
        $error("battleship_turn_ctrl: illegal parameter value");
    end

    state_t                state_q, state_d;
    logic [GRID_CELLS-1:0] p1_board_q, p1_board_d;
    logic [GRID_CELLS-1:0] p2_board_q, p2_board_d;
    logic [GRID_CELLS-1:0] p1_mask_q, p1_mask_d;
    logic [GRID_CELLS-1:0] p2_mask_q, p2_mask_d;
    logic [CW-1:0]         p1_cnt_q, p1_cnt_d;
    logic [CW-1:0]         p2_cnt_q, p2_cnt_d;
    logic [RW-1:0]         res_cnt_q, res_cnt_d;
    logic                  res_hit_q, res_hit_d;

    logic start_q, start_d;
    logic p1fire_q, p1fire_d;
    logic p2fire_q, p2fire_d;
    logic p1hit_q, p1hit_d;
    logic p1miss_q, p1miss_d;
    logic p2hit_q, p2hit_d;
    logic p2miss_q, p2miss_d;
    logic p1wins_q, p1wins_d;
    logic p2wins_q, p2wins_d;

`ifdef TURN_TIMEOUT_EN
    localparam int AW = (AIM_TIMEOUT > 1) ? $clog2(AIM_TIMEOUT) : 1;
    localparam logic [AW-1:0] AIM_LOAD = AW'(AIM_TIMEOUT - 1);
    logic [AW-1:0] aim_cnt_q, aim_cnt_d;
    logic          aim_expired;
`endif

    logic [GRID_CELLS-1:0] cell_sel;
    logic                  target_ok;
    logic                  p1_shot_ok, p2_shot_ok;
    logic                  p1_scores, p2_scores;

    always_comb begin
        cell_sel   = CELL_ONE << target;
        target_ok  = 32'(target) < GRID_CELLS;
        p1_shot_ok = fire && target_ok && ((p1_mask_q & cell_sel) == '0);
        p2_shot_ok = fire && target_ok && ((p2_mask_q & cell_sel) == '0);
        p1_scores  = (p2_board_q & cell_sel) != '0;
        p2_scores  = (p1_board_q & cell_sel) != '0;
    end

    always_comb begin
        state_d    = state_q;
        p1_board_d = p1_board_q;
        p2_board_d = p2_board_q;
        p1_mask_d  = p1_mask_q;
        p2_mask_d  = p2_mask_q;
        p1_cnt_d   = p1_cnt_q;
        p2_cnt_d   = p2_cnt_q;
        res_hit_d  = res_hit_q;
`ifdef TURN_TIMEOUT_EN
        aim_expired = (aim_cnt_q == '0);
`endif

        case (state_q)
            S_IDLE: begin
                if (start_btn) begin
                    p1_board_d = p1_board;
                    p2_board_d = p2_board;
                    p1_mask_d  = '0;
                    p2_mask_d  = '0;
                    p1_cnt_d   = '0;
                    p2_cnt_d   = '0;
                    state_d    = S_P1_AIM;
                end
            end
            S_P1_AIM: begin
                if (p1_shot_ok) begin
                    p1_mask_d = p1_mask_q | cell_sel;
                    res_hit_d = p1_scores;
                    if (p1_scores && p1_cnt_q != SHIP_MAX) p1_cnt_d = p1_cnt_q + 1'b1;
                    state_d = S_P1_RESULT;
                end
`ifdef TURN_TIMEOUT_EN
                else if (aim_expired) begin
                    res_hit_d = 1'b0;
                    state_d   = S_P1_RESULT;
                end
`endif
            end
            S_P1_RESULT: begin
                if (res_cnt_q == '0) state_d = (p1_cnt_q == SHIP_MAX) ? S_P1_WIN : S_P2_AIM;
            end
            S_P2_AIM: begin
                if (p2_shot_ok) begin
                    p2_mask_d = p2_mask_q | cell_sel;
                    res_hit_d = p2_scores;
                    if (p2_scores && p2_cnt_q != SHIP_MAX) p2_cnt_d = p2_cnt_q + 1'b1;
                    state_d = S_P2_RESULT;
                end
`ifdef TURN_TIMEOUT_EN
                else if (aim_expired) begin
                    res_hit_d = 1'b0;
                    state_d   = S_P2_RESULT;
                end
`endif
            end
            S_P2_RESULT: begin
                if (res_cnt_q == '0) state_d = (p2_cnt_q == SHIP_MAX) ? S_P2_WIN : S_P1_AIM;
            end
            S_P1_WIN, S_P2_WIN: begin
                if (start_btn) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Timers sit at their load value outside the state they time, so entry needs no extra logic
        res_cnt_d = RES_LOAD;
        if (state_q == S_P1_RESULT || state_q == S_P2_RESULT) begin
            res_cnt_d = (res_cnt_q != '0) ? res_cnt_q - 1'b1 : res_cnt_q;
        end
`ifdef TURN_TIMEOUT_EN
        aim_cnt_d = AIM_LOAD;
        if (state_q == S_P1_AIM || state_q == S_P2_AIM) begin
            aim_cnt_d = (aim_cnt_q != '0) ? aim_cnt_q - 1'b1 : aim_cnt_q;
        end
`endif

        start_d  = (state_d == S_IDLE);
        p1fire_d = (state_d == S_P1_AIM) || (state_d == S_P1_RESULT);
        p2fire_d = (state_d == S_P2_AIM) || (state_d == S_P2_RESULT);
        p2hit_d  = (state_d == S_P1_RESULT) && res_hit_d;
        p2miss_d = (state_d == S_P1_RESULT) && !res_hit_d;
        p1hit_d  = (state_d == S_P2_RESULT) && res_hit_d;
        p1miss_d = (state_d == S_P2_RESULT) && !res_hit_d;
        p1wins_d = (state_d == S_P1_WIN);
        p2wins_d = (state_d == S_P2_WIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            p1_board_q <= '0;
            p2_board_q <= '0;
            p1_mask_q  <= '0;
            p2_mask_q  <= '0;
            p1_cnt_q   <= '0;
            p2_cnt_q   <= '0;
            res_cnt_q  <= '0;
            res_hit_q  <= 1'b0;
            start_q    <= 1'b1;
            p1fire_q   <= 1'b0;
            p2fire_q   <= 1'b0;
            p1hit_q    <= 1'b0;
            p1miss_q   <= 1'b0;
            p2hit_q    <= 1'b0;
            p2miss_q   <= 1'b0;
            p1wins_q   <= 1'b0;
            p2wins_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            aim_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            p1_board_q <= p1_board_d;
            p2_board_q <= p2_board_d;
            p1_mask_q  <= p1_mask_d;
            p2_mask_q  <= p2_mask_d;
            p1_cnt_q   <= p1_cnt_d;
            p2_cnt_q   <= p2_cnt_d;
            res_cnt_q  <= res_cnt_d;
            res_hit_q  <= res_hit_d;
            start_q    <= start_d;
            p1fire_q   <= p1fire_d;
            p2fire_q   <= p2fire_d;
            p1hit_q    <= p1hit_d;
            p1miss_q   <= p1miss_d;
            p2hit_q    <= p2hit_d;
            p2miss_q   <= p2miss_d;
            p1wins_q   <= p1wins_d;
            p2wins_q   <= p2wins_d;
`ifdef TURN_TIMEOUT_EN
            aim_cnt_q  <= aim_cnt_d;
`endif
        end
    end

    assign start  = start_q;
    assign p1fire = p1fire_q;
    assign p2fire = p2fire_q;
    assign p1hit  = p1hit_q;
    assign p1miss = p1miss_q;
    assign p2hit  = p2hit_q;
    assign p2miss = p2miss_q;
    assign p1wins = p1wins_q;
    assign p2wins = p2wins_q;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed bench for battleship_turn_ctrl with short hold/timeout parameters.
module tb_battleship_turn_ctrl;

    localparam int GC = 36;
    localparam int SC = 2;
    localparam int RC = 4;
    localparam int AT = 8;

    // {start, p1fire, p2fire, p1hit, p1miss, p2hit, p2miss, p1wins, p2wins}
    localparam logic [8:0] O_IDLE     = 9'h100;
    localparam logic [8:0] O_P1AIM    = 9'h080;
    localparam logic [8:0] O_P2AIM    = 9'h040;
    localparam logic [8:0] O_P1R_HIT  = 9'h088;
    localparam logic [8:0] O_P1R_MISS = 9'h084;
    localparam logic [8:0] O_P2R_HIT  = 9'h060;
    localparam logic [8:0] O_P2R_MISS = 9'h050;
    localparam logic [8:0] O_P1WIN    = 9'h002;
    localparam logic [8:0] O_P2WIN    = 9'h001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_btn;
    logic          fire;
    logic [5:0]    target;
    logic [GC-1:0] p1_board;
    logic [GC-1:0] p2_board;
    logic start, p1fire, p2fire, p1hit, p1miss, p2hit, p2miss, p1wins, p2wins;
    logic [8:0] outs;

    int checks = 0;
    int failures = 0;

    battleship_turn_ctrl #(
        .GRID_CELLS(GC), .SHIP_CELLS(SC), .RESULT_CYCLES(RC), .AIM_TIMEOUT(AT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .fire(fire), .target(target),
        .p1_board(p1_board), .p2_board(p2_board), .start(start),
        .p1fire(p1fire), .p2fire(p2fire), .p1hit(p1hit), .p1miss(p1miss),
        .p2hit(p2hit), .p2miss(p2miss), .p1wins(p1wins), .p2wins(p2wins)
    );

    always #5 clk = ~clk;

    assign outs = {start, p1fire, p2fire, p1hit, p1miss, p2hit, p2miss, p1wins, p2wins};

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    task automatic shoot(input logic [5:0] t);
        target = t;
        fire   = 1'b1;
        step();
        fire   = 1'b0;
    endtask

    task automatic hold(input string tag, input logic [8:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_eq(tag, outs, exp);
        end
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        start_btn = 1'b0;
        fire      = 1'b0;
        target    = '0;
        p1_board  = 36'h18;
        p2_board  = 36'h220;
        #2 rst_n = 1'b0;
        #10;
        check_eq("reset_idle", outs, O_IDLE);
        rst_n = 1'b1;
        step();
        check_eq("idle_hold", outs, O_IDLE);

        // game 1: player 1 wins
        press_start();
        check_eq("start_p1aim", outs, O_P1AIM);
        p2_board = '0;
        shoot(6'd5);
        check_eq("p1_hit", outs, O_P1R_HIT);
        hold("p1_hit_hold", O_P1R_HIT, 2);
        shoot(6'd9);
        check_eq("fire_in_result_ignored", outs, O_P1R_HIT);
        step();
        check_eq("to_p2aim", outs, O_P2AIM);
        shoot(6'd40);
        check_eq("oob_ignored", outs, O_P2AIM);
        shoot(6'd7);
        check_eq("p2_miss", outs, O_P2R_MISS);
        hold("p2_miss_hold", O_P2R_MISS, 3);
        step();
        check_eq("to_p1aim", outs, O_P1AIM);
        press_start();
        check_eq("start_ignored_aim", outs, O_P1AIM);
        shoot(6'd5);
        check_eq("p1_reshot_ignored", outs, O_P1AIM);
        shoot(6'd0);
        check_eq("p1_miss", outs, O_P1R_MISS);
        hold("p1_miss_hold", O_P1R_MISS, 3);
        step();
        check_eq("to_p2aim_2", outs, O_P2AIM);
        shoot(6'd7);
        check_eq("p2_reshot_ignored", outs, O_P2AIM);
        shoot(6'd3);
        check_eq("p2_hit", outs, O_P2R_HIT);
        hold("p2_hit_hold", O_P2R_HIT, 3);
        step();
        check_eq("to_p1aim_2", outs, O_P1AIM);
        shoot(6'd9);
        check_eq("p1_hit_latched_board", outs, O_P1R_HIT);
        hold("p1_hit2_hold", O_P1R_HIT, 3);
        step();
        check_eq("p1_wins", outs, O_P1WIN);
        hold("p1_wins_sticky", O_P1WIN, 3);
        shoot(6'd1);
        check_eq("fire_in_win_ignored", outs, O_P1WIN);
        press_start();
        check_eq("win_to_idle", outs, O_IDLE);

        // game 2: reset abandons a game in P1_RESULT
        p2_board = 36'h220;
        press_start();
        check_eq("g2_p1aim", outs, O_P1AIM);
        shoot(6'd5);
        check_eq("g2_p1_hit", outs, O_P1R_HIT);
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_mid_result", outs, O_IDLE);
        #2 rst_n = 1'b1;
        step();
        check_eq("idle_after_reset", outs, O_IDLE);

        // game 3: cleared masks and counters; player 2 wins
        press_start();
        check_eq("g3_p1aim", outs, O_P1AIM);
        shoot(6'd5);
        check_eq("g3_mask_cleared", outs, O_P1R_HIT);
        hold("g3_p1_hold", O_P1R_HIT, 3);
        step();
        check_eq("g3_counter_cleared", outs, O_P2AIM);
        shoot(6'd3);
        check_eq("g3_p2_hit", outs, O_P2R_HIT);
        hold("g3_p2_hold", O_P2R_HIT, 3);
        step();
        check_eq("g3_p1aim_2", outs, O_P1AIM);
        shoot(6'd0);
        check_eq("g3_p1_miss", outs, O_P1R_MISS);
        hold("g3_p1_miss_hold", O_P1R_MISS, 3);
        step();
        check_eq("g3_p2aim_2", outs, O_P2AIM);
        shoot(6'd4);
        check_eq("g3_p2_hit2", outs, O_P2R_HIT);
        hold("g3_p2_hit2_hold", O_P2R_HIT, 3);
        step();
        check_eq("p2_wins", outs, O_P2WIN);
        hold("p2_wins_sticky", O_P2WIN, 2);
        press_start();
        check_eq("g3_to_idle", outs, O_IDLE);

`ifdef TURN_TIMEOUT_EN
        press_start();
        check_eq("to_p1aim_timeout", outs, O_P1AIM);
        hold("aim_before_timeout", O_P1AIM, AT - 1);
        step();
        check_eq("timeout_miss", outs, O_P1R_MISS);
        hold("timeout_miss_hold", O_P1R_MISS, 3);
        step();
        check_eq("timeout_to_p2aim", outs, O_P2AIM);
        shoot(6'd0);
        check_eq("to_p2_miss", outs, O_P2R_MISS);
        hold("to_p2_miss_hold", O_P2R_MISS, 3);
        step();
        check_eq("to_p1aim_again", outs, O_P1AIM);
        hold("aim_before_expiry", O_P1AIM, AT - 1);
        shoot(6'd5);
        check_eq("expiry_fire_wins", outs, O_P1R_HIT);
        hold("expiry_hit_hold", O_P1R_HIT, 3);
        step();
        check_eq("timeout_count_unchanged", outs, O_P2AIM);
`else
        press_start();
        check_eq("to_p1aim_no_timeout", outs, O_P1AIM);
        hold("aim_waits", O_P1AIM, 20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
